cell_pos_access_ctrl: RTL and testbench

Sequencer and arbiter for one single-port cell position memory. Address 0 of that memory holds the cell's particle count; addresses 1..N hold {posz, posy, posx}. On a read request the block fetches the count, then streams particles 1..N to the force-evaluation side with valid/last tags. It also grants single-word writes from the motion-update side whenever no stream is in progress. It sits between the position cache logic and each per-cell RAM instance, and absorbs the RAM's 2-cycle read latency.

---
 rtl/cell_ctrl_pkg.sv | 20 ++
 rtl/cell_rd_valid_pipe.sv | 32 +++
 rtl/cell_pos_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_cell_pos_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_ctrl_pkg.sv
// Shared definitions for the cell position memory sequencer: FSM states and
// fixed memory-map / latency constants.
package cell_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    HDR_W1,
    HDR_W2,
    STREAM,
    DRAIN1,
    DRAIN2,
    DRAIN3,
    DONE
  } cell_state_e;

  localparam int HDR_ADDR   = 0;
  localparam int RD_LATENCY = 2;

endpackage

// File: rtl/cell_rd_valid_pipe.sv
// Shift register carrying {valid, last, pid} alongside the RAM read latency so
// the tags line up with mem_q.
module cell_rd_valid_pipe #(
  parameter int DEPTH     = 2,
  parameter int PID_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [PID_WIDTH-1:0] in_pid,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [PID_WIDTH-1:0] out_pid
);

  localparam int W = PID_WIDTH + 2;

  logic [W-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= {in_valid, in_last, in_pid};
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign {out_valid, out_last, out_pid} = stage_reg[DEPTH-1];

endmodule

// File: rtl/cell_pos_access_ctrl.sv
// Read sequencer / write arbiter for one single-port cell position RAM.
// Optional macro CELL_CTRL_RD_REG_EN adds an output register on the read stream.
module cell_pos_access_ctrl
  import cell_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_pid,
  output logic                  rd_last,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

`ifdef CELL_CTRL_RD_REG_EN
  localparam int PIPE_DEPTH = RD_LATENCY + 1;
`else
  localparam int PIPE_DEPTH = RD_LATENCY;
`endif

  cell_state_e           state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] count_reg;
  logic                  count_err_reg;
  logic [ADDR_WIDTH-1:0] count_raw;
  logic                  wr_grant;
  logic                  issue;
  logic                  issue_last;

  assign count_raw  = mem_q[ADDR_WIDTH-1:0];
  assign issue      = (state_reg == STREAM);
  assign issue_last = issue && (addr_reg == count_reg);
  // rst_n gate keeps wr_ack/mem_wren low while reset is held, even if wr_req is high
  assign wr_grant   = rst_n && (state_reg == IDLE) && wr_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      count_reg     <= '0;
      count_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE:   if (!wr_req && rd_start) state_reg <= HDR;
        HDR:    state_reg <= HDR_W1;
        HDR_W1: state_reg <= HDR_W2;
        HDR_W2: begin
          if (count_raw > MAX_COUNT) begin
            count_reg     <= MAX_COUNT;
            count_err_reg <= 1'b1;
          end else begin
            count_reg <= count_raw;
          end
          addr_reg  <= ADDR_WIDTH'(1);
          state_reg <= (count_raw == '0) ? DONE : STREAM;
        end
        STREAM: begin
          if (addr_reg == count_reg) state_reg <= DRAIN1;
          else                       addr_reg  <= addr_reg + ADDR_WIDTH'(1);
        end
        DRAIN1: state_reg <= DRAIN2;
`ifdef CELL_CTRL_RD_REG_EN
        DRAIN2: state_reg <= DRAIN3;
        DRAIN3: state_reg <= DONE;
`else
        DRAIN2: state_reg <= DONE;
`endif
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    if (wr_grant) begin
      mem_address = wr_addr;
      mem_data    = wr_data;
      mem_wren    = 1'b1;
    end else if (state_reg == HDR) begin
      mem_address = ADDR_WIDTH'(HDR_ADDR);
      mem_rden    = 1'b1;
    end else if (issue) begin
      mem_address = addr_reg;
      mem_rden    = 1'b1;
    end
  end

  assign wr_ack         = wr_grant;
  assign rd_busy        = (state_reg != IDLE);
  assign rd_done        = (state_reg == DONE);
  assign particle_count = count_reg;
  assign count_err      = count_err_reg;

  cell_rd_valid_pipe #(
    .DEPTH    (PIPE_DEPTH),
    .PID_WIDTH(ADDR_WIDTH)
  ) u_valid_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (issue),
    .in_last  (issue_last),
    .in_pid   (issue ? addr_reg : '0),
    .out_valid(rd_valid),
    .out_last (rd_last),
    .out_pid  (rd_pid)
  );

`ifdef CELL_CTRL_RD_REG_EN
  logic [DATA_WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_reg <= '0;
    else        data_reg <= mem_q;
  end

  assign rd_data = rd_valid ? data_reg : '0;
`else
  assign rd_data = rd_valid ? mem_q : '0;
`endif

endmodule

// File: tb/tb_cell_pos_access_ctrl.sv
// Scoreboard bench for cell_pos_access_ctrl with a 2-cycle-latency RAM model.
module tb_cell_pos_access_ctrl;

`ifdef CELL_CTRL_RD_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_start = 1'b0;
  logic        rd_busy, rd_valid, rd_last, rd_done, count_err, wr_ack;
  logic [95:0] rd_data, mem_data, mem_q;
  logic [7:0]  rd_pid, particle_count, mem_address;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [95:0] wr_data = '0;
  logic        mem_rden, mem_wren;

  cell_pos_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_busy(rd_busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_pid(rd_pid), .rd_last(rd_last),
    .rd_done(rd_done), .particle_count(particle_count), .count_err(count_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: q valid two cycles after address/rden
  logic [95:0] ram [0:255];
  logic [95:0] q1 = '0, q2 = '0;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    q1 <= mem_rden ? ram[mem_address] : '0;
    q2 <= q1;
  end
  assign mem_q = q2;

  typedef struct {
    int          cyc;
    logic [7:0]  a;
    logic [95:0] d;
    logic        last;
  } exp_t;

  exp_t iss_q[$], rd_q[$], wr_q[$], done_q[$];
  logic [95:0] ref_mem [0:255];
  int checks = 0, errors = 0, valid_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [95:0] pat(input int i);
    return {32'hC000_0000 | 32'(i), 32'hB000_0000 | 32'(i * 3), 32'hA000_0000 | 32'(i * 7)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_rden && mem_wren) chk("rden_wren_excl", 128'(mem_wren), 128'(0));
      if (mem_rden) begin
        if (iss_q.size() == 0) chk("unexpected_issue", 128'(mem_rden), 128'(0));
        else begin
          e = iss_q.pop_front();
          chk("issue_cycle", 128'(cyc), 128'(e.cyc));
          chk("issue_addr", 128'(mem_address), 128'(e.a));
        end
      end
      if (mem_wren || wr_ack) begin
        if (wr_q.size() == 0) chk("unexpected_ack", 128'(wr_ack), 128'(0));
        else begin
          e = wr_q.pop_front();
          $display("write addr=%0d data=%0h cycle=%0d", mem_address, mem_data, cyc);
          chk("wr_cycle", 128'(cyc), 128'(e.cyc));
          chk("wr_strobes", 128'({wr_ack, mem_wren}), 128'(2'b11));
          chk("wr_addr", 128'(mem_address), 128'(e.a));
          chk("wr_data", 128'(mem_data), 128'(e.d));
        end
      end
      if (rd_valid) begin
        valid_cnt++;
        if (rd_q.size() == 0) chk("unexpected_valid", 128'(rd_valid), 128'(0));
        else begin
          e = rd_q.pop_front();
          $display("read pid=%0d data=%0h last=%0b cycle=%0d", rd_pid, rd_data, rd_last, cyc);
          chk("rd_cycle", 128'(cyc), 128'(e.cyc));
          chk("rd_pid", 128'(rd_pid), 128'(e.a));
          chk("rd_data", 128'(rd_data), 128'(e.d));
          chk("rd_last", 128'(rd_last), 128'(e.last));
        end
      end else if (rd_last) chk("stray_last", 128'(rd_last), 128'(0));
      if (rd_done) begin
        if (done_q.size() == 0) chk("unexpected_done", 128'(rd_done), 128'(0));
        else begin
          e = done_q.pop_front();
          $display("done count=%0d cycle=%0d", particle_count, cyc);
          chk("done_cycle", 128'(cyc), 128'(e.cyc));
          chk("done_count", 128'(particle_count), 128'(e.a));
        end
      end
    end
  end

  // Expected transactions of one stream whose rd_start is driven while cyc == base.
  task automatic push_stream(input int base);
    int n;
    n = int'(ref_mem[0][7:0]);
    if (n > 219) n = 219;
    iss_q.push_back('{base + 1, 8'd0, 96'd0, 1'b0});
    for (int i = 1; i <= n; i++) begin
      iss_q.push_back('{base + 3 + i, 8'(i), 96'd0, 1'b0});
      rd_q.push_back('{base + 5 + i + EXTRA, 8'(i), ref_mem[i], i == n});
    end
    done_q.push_back('{(n == 0) ? base + 4 : base + 6 + n + EXTRA, 8'(n), 96'd0, 1'b0});
  endtask

  task automatic launch(output int base);
    base = cyc;
    rd_start = 1'b1;
    push_stream(base);
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic write_wait(input logic [7:0] a, input logic [95:0] d, input int exp_cyc);
    bit got = 0;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    wr_q.push_back('{exp_cyc, a, d, 1'b0});
    ref_mem[a] = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wr_ack) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wr_ack_timeout: got no ack required ack for addr %0d", a);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!rd_busy && iss_q.size() == 0 && rd_q.size() == 0 && done_q.size() == 0) begin
        ok = 1; break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d required idle with none pending",
               rd_busy, iss_q.size() + rd_q.size() + done_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, 128'({rd_busy, rd_valid, rd_last, rd_done, count_err, wr_ack,
                             mem_rden, mem_wren, rd_pid, particle_count, mem_address}), 128'(0));
    chk({tag, "_rd_data"}, 128'(rd_data), 128'(0));
    chk({tag, "_mem_data"}, 128'(mem_data), 128'(0));
  endtask

  initial begin
    int base, v0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload particles and a header of 3 through the write port
    for (int i = 1; i <= 219; i++) write_wait(8'(i), pat(i), cyc);
    write_wait(8'd0, 96'd3, cyc);

    // Header 3
    launch(base);
    wait_idle();
    chk("count_hdr3", 128'(particle_count), 128'(3));
    chk("err_hdr3", 128'(count_err), 128'(0));

    // Header 0: done in cycle 4, busy drops in cycle 5
    write_wait(8'd0, 96'd0, cyc);
    launch(base);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_in_done", 128'(rd_busy), 128'(1));
    @(negedge clk);
    chk("busy_after_done", 128'(rd_busy), 128'(0));
    wait_idle();
    chk("count_hdr0", 128'(particle_count), 128'(0));

    // Header 250 clamps to 219
    write_wait(8'd0, 96'd250, cyc);
    v0 = valid_cnt;
    launch(base);
    wait_idle();
    chk("count_clamp", 128'(particle_count), 128'(219));
    chk("err_set", 128'(count_err), 128'(1));
    chk("valid_pulses", 128'(valid_cnt - v0), 128'(219));

    // Simultaneous write and read: write wins, read accepted next cycle
    write_wait(8'd0, 96'd5, cyc);
    rd_start = 1'b1;
    write_wait(8'd5, 96'h1234_5678_9ABC_DEF0_0F1E_2D3C, cyc);
    base = cyc - 1;
    push_stream(base + 1);
    @(posedge clk); #1;
    rd_start = 1'b0;
    wait_idle();
    chk("err_sticky1", 128'(count_err), 128'(1));

    // Write raised mid-stream is deferred to the cycle after rd_done
    write_wait(8'd0, 96'd3, cyc);
    launch(base);
    @(posedge clk); #1;
    @(posedge clk); #1;
    write_wait(8'd2, 96'hDEAD_BEEF_0000_1111_2222_3333, base + 10 + EXTRA);
    wait_idle();
    launch(base);
    wait_idle();
    chk("err_sticky2", 128'(count_err), 128'(1));

    // Reset during STREAM aborts silently
    write_wait(8'd0, 96'd10, cyc);
    launch(base);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    iss_q.delete(); rd_q.delete(); done_q.delete(); wr_q.delete();
    #1;
    check_outputs_zero("abort");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    write_wait(8'd0, 96'd3, cyc);
    launch(base);
    wait_idle();
    chk("count_after_rst", 128'(particle_count), 128'(3));
    chk("err_after_rst", 128'(count_err), 128'(0));

    chk("leftover", 128'(iss_q.size() + rd_q.size() + wr_q.size() + done_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
